// File: rtl/bip_pkg.sv
// BIP-I control types and encodings.
// Shared by the decoder and the control unit.
package bip_pkg;

  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;

  localparam logic [1:0] SELA_DM   = 2'd0;
  localparam logic [1:0] SELA_OPER = 2'd1;
  localparam logic [1:0] SELA_ALU  = 2'd2;

  localparam logic SELB_DM   = 1'b0;
  localparam logic SELB_OPER = 1'b1;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
    logic       is_halt;
  } ctrl_t;

endpackage

// File: rtl/bip_instr_decoder.sv
// Combinational BIP-I opcode decoder.
// Ports: opc (5-bit opcode) -> ctrl (selects, op, enables, is_halt).
module bip_instr_decoder
  import bip_pkg::*;
(
  input  logic [4:0] opc,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      (opc == OPC_HLT): begin
        ctrl.is_halt = 1'b1;
      end
      (opc == OPC_STO): begin
        ctrl.wr_ram = 1'b1;
      end
      (opc == OPC_LD): begin
        ctrl.sel_a  = SELA_DM;
        ctrl.wr_acc = 1'b1;
        ctrl.rd_ram = 1'b1;
      end
      (opc == OPC_LDI): begin
        ctrl.sel_a  = SELA_OPER;
        ctrl.wr_acc = 1'b1;
      end
      (opc == OPC_ADD): begin
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = SELB_DM;
        ctrl.op     = OP_ADD;
        ctrl.wr_acc = 1'b1;
        ctrl.rd_ram = 1'b1;
      end
      (opc == OPC_ADDI): begin
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = SELB_OPER;
        ctrl.op     = OP_ADD;
        ctrl.wr_acc = 1'b1;
      end
      (opc == OPC_SUB): begin
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = SELB_DM;
        ctrl.op     = OP_SUB;
        ctrl.wr_acc = 1'b1;
        ctrl.rd_ram = 1'b1;
      end
      (opc == OPC_SUBI): begin
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = SELB_OPER;
        ctrl.op     = OP_SUB;
        ctrl.wr_acc = 1'b1;
      end
      default: begin
        // Unassigned opcodes are NOPs.
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// BIP-I control unit: PC, decode, run/halt/step FSM, cycle count.
// Ports: i_clk, i_rst (async low), i_start, i_step_mode, i_step,
// i_instr in; PM address, operand, datapath controls, status out.
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int PC_W  = 11,
  parameter int OPC_W = 5,
  parameter int CNT_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic [OPC_W+PC_W-1:0] i_instr,
  output logic [PC_W-1:0]       o_addr_pm,
  output logic [PC_W-1:0]       o_operand,
  output logic [1:0]            o_selA,
  output logic                  o_selB,
  output logic                  o_WrAcc,
  output logic                  o_Op,
  output logic                  o_WrRam,
  output logic                  o_RdRam,
  output logic                  o_halt,
  output logic                  o_running,
  output logic [CNT_W-1:0]      o_cycles
);

  ctrl_t            dec;
  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] cycles;
  logic             halt_q;
  logic             run_q;
  logic             advance;

  bip_instr_decoder u_dec (
    .opc  (i_instr[OPC_W+PC_W-1:PC_W]),
    .ctrl (dec)
  );

  assign advance = (state == ST_RUN) &&
                   (!i_step_mode || i_step);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state  <= ST_IDLE;
      pc     <= '0;
      cycles <= '0;
      halt_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_HALT: begin
          if (i_start) begin
            state  <= ST_RUN;
            pc     <= '0;
            cycles <= '0;
            halt_q <= 1'b0;
            run_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (advance) begin
            if (cycles != '1)
              cycles <= cycles + CNT_W'(1);
            if (dec.is_halt) begin
              // PC keeps pointing at the HLT.
              state  <= ST_HALT;
              halt_q <= 1'b1;
              run_q  <= 1'b0;
            end else begin
              pc <= pc + PC_W'(1);
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          halt_q <= 1'b0;
          run_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_addr_pm = pc;
  assign o_operand = i_instr[PC_W-1:0];
  assign o_cycles  = cycles;
  assign o_halt    = halt_q;
  assign o_running = run_q;

  // Selects are held at zero while reset is asserted.
  assign o_selA = i_rst ? dec.sel_a : '0;
  assign o_selB = i_rst ? dec.sel_b : 1'b0;
  assign o_Op   = i_rst ? dec.op    : 1'b0;

  assign o_WrAcc = dec.wr_acc & advance;
  assign o_WrRam = dec.wr_ram & advance;
  assign o_RdRam = dec.rd_ram & advance;

endmodule

// File: tb/tb_bip_control_unit.sv
// Self-checking bench for bip_control_unit.
// Vector table, directed sequences and randomized model comparison.
module tb_bip_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic [15:0] instr;
  logic [10:0] addr;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic        wr_acc;
  logic        op;
  logic        wr_ram;
  logic        rd_ram;
  logic        halt;
  logic        running;
  logic [31:0] cycles;

  logic [15:0] mem [2048];
  logic        use_tbl = 1'b0;
  logic [15:0] tbl_instr = '0;

  int checks = 0;
  int errors = 0;

  assign instr = use_tbl ? tbl_instr : mem[addr];

  always #5 clk = ~clk;

  bip_control_unit dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_start     (start),
    .i_step_mode (step_mode),
    .i_step      (step),
    .i_instr     (instr),
    .o_addr_pm   (addr),
    .o_operand   (operand),
    .o_selA      (sel_a),
    .o_selB      (sel_b),
    .o_WrAcc     (wr_acc),
    .o_Op        (op),
    .o_WrRam     (wr_ram),
    .o_RdRam     (rd_ram),
    .o_halt      (halt),
    .o_running   (running),
    .o_cycles    (cycles)
  );

  // Reference decode {selA, selB, Op, WrAcc, WrRam, RdRam}
  // for opcodes 0..7; everything above is a NOP.
  localparam logic [6:0] REF [8] = '{
    7'b0000000, 7'b0000010, 7'b0000101, 7'b0100100,
    7'b1001101, 7'b1011100, 7'b1000101, 7'b1010100
  };

  localparam logic [15:0] NOP = 16'hF800;

  typedef struct {
    logic [4:0] opc;
    logic [1:0] sa;
    logic       sb;
    logic       op;
    logic       wa;
    logic       wr;
    logic       rr;
  } vec_t;

  vec_t tbl [12];

  bit          m_run;
  bit          m_halt;
  int unsigned m_pc;
  longint      m_cyc;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [4:0] o,
                                      input logic [10:0] v);
    return {o, v};
  endfunction

  function automatic logic [6:0] ref_dec(input logic [4:0] o);
    if (o > 5'd7) return 7'd0;
    return REF[o[2:0]];
  endfunction

  task automatic fill(input logic [15:0] w);
    for (int i = 0; i < 2048; i++) mem[i] = w;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    step = 1'b0;
    step_mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [63:0] dut_vec();
    return 64'({addr, operand, sel_a, sel_b, op, wr_acc,
                wr_ram, rd_ram, halt, running, cycles});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  prog_exp [4];
    logic [10:0] prog_opnd [4];
    logic [1:0]  mem_sa [3];
    int          pulses;
    bit          found;
    logic [15:0] w;
    logic [6:0]  d;
    bit          adv;
    logic [63:0] ev;

    tbl[0]  = '{5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{5'd1,  2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{5'd2,  2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{5'd3,  2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{5'd4,  2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{5'd5,  2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{5'd6,  2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{5'd7,  2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{5'd8,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{5'd15, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{5'd21, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{5'd31, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    prog_exp[0] = 6'b01_0_0_1_0;
    prog_exp[1] = 6'b10_1_1_1_0;
    prog_exp[2] = 6'b10_1_0_1_0;
    prog_exp[3] = 6'b00_0_0_0_1;
    prog_opnd[0] = 11'd3;
    prog_opnd[1] = 11'd1;
    prog_opnd[2] = 11'd2;
    prog_opnd[3] = 11'd7;
    mem_sa[0] = 2'd0;
    mem_sa[1] = 2'd2;
    mem_sa[2] = 2'd2;

    // Reset state
    fill(NOP);
    #2;
    chk("rst_vec", dut_vec(), 64'({11'd0, 11'h000, 11'd0, 32'd0}));
    do_reset();

    // LDI 3; ADDI 1; SUBI 2; STO 7; HLT
    mem[0] = enc(5'd3, 11'd3);
    mem[1] = enc(5'd5, 11'd1);
    mem[2] = enc(5'd7, 11'd2);
    mem[3] = enc(5'd1, 11'd7);
    mem[4] = enc(5'd0, 11'd0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("prog_ctl", 64'({sel_a, sel_b, op, wr_acc, wr_ram}),
          64'(prog_exp[i]));
      chk("prog_opnd", 64'(operand), 64'(prog_opnd[i]));
      @(negedge clk);
    end
    #1;
    chk("prog_hlt_ctl", 64'({sel_a, sel_b, op, wr_acc,
                             wr_ram, rd_ram}), 64'd0);
    @(negedge clk);
    #1;
    chk("prog_halt", 64'({halt, running, addr, cycles}),
        64'({1'b1, 1'b0, 11'd4, 32'd5}));

    // Restart from HALT with a coincident step pulse
    mem[0] = enc(5'd2, 11'd10);
    mem[1] = enc(5'd4, 11'd11);
    mem[2] = enc(5'd6, 11'd12);
    mem[3] = enc(5'd0, 11'd0);
    @(negedge clk);
    step_mode = 1'b1;
    step = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    step = 1'b0;
    #1;
    chk("restart", 64'({halt, running, addr, cycles}),
        64'({1'b0, 1'b1, 11'd0, 32'd0}));
    step_mode = 1'b0;

    // LD 10; ADD 11; SUB 12 with a start pulse mid-run
    for (int i = 0; i < 3; i++) begin
      if (i == 1) start = 1'b1;
      #1;
      chk("mem_rd", 64'({rd_ram, wr_acc, sel_b}), 64'(3'b110));
      chk("mem_sa", 64'(sel_a), 64'(mem_sa[i]));
      if (i > 0) chk("mem_op", 64'(op), 64'(i == 1));
      if (i == 2) chk("run_start_pc", 64'(addr), 64'd2);
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    #1;
    chk("mem_halt", 64'({halt, addr, cycles}),
        64'({1'b1, 11'd3, 32'd4}));

    // Step mode, pulses every third cycle
    do_reset();
    fill(NOP);
    mem[0] = enc(5'd3, 11'd1);
    mem[1] = enc(5'd5, 11'd2);
    mem[2] = enc(5'd7, 11'd3);
    mem[3] = enc(5'd1, 11'd4);
    mem[4] = enc(5'd0, 11'd0);
    step_mode = 1'b1;
    pulse_start();
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      step = (c % 3 == 2);
      #1;
      chk("step_state", 64'({addr, cycles}),
          64'({11'(pulses), 32'(pulses)}));
      chk("step_en", 64'(wr_acc | wr_ram | rd_ram),
          64'(step && pulses < 4));
      if (step) pulses++;
      @(negedge clk);
      step = 1'b0;
    end
    #1;
    chk("step_halt", 64'({halt, addr, cycles}),
        64'({1'b1, 11'd4, 32'd5}));

    // Async reset mid-RUN at PC=5
    do_reset();
    fill(enc(5'd3, 11'd9));
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (addr == 11'd5) found = 1'b1;
      else @(negedge clk);
    end
    chk("rst_reach", 64'(found), 64'd1);
    #1;
    chk("rst_pre_wr", 64'(wr_acc), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", 64'({addr, cycles, running, wr_acc,
                          wr_ram, rd_ram, sel_a}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // PC wrap across a NOP at 2047
    fill(NOP);
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < 2100 && !found; k++) begin
      if (addr == 11'd2047) found = 1'b1;
      else @(negedge clk);
    end
    chk("wrap_reach", 64'(found), 64'd1);
    #1;
    chk("wrap_nop", 64'({wr_acc, wr_ram, rd_ram, cycles}),
        64'({3'b000, 32'd2047}));
    @(negedge clk);
    #1;
    chk("wrap_pc", 64'({addr, cycles}), 64'({11'd0, 32'd2048}));

    // Decode vector table, stalled in step mode
    do_reset();
    use_tbl = 1'b1;
    step_mode = 1'b1;
    pulse_start();
    foreach (tbl[i]) begin
      tbl_instr = enc(tbl[i].opc, 11'($urandom));
      step = 1'b0;
      #1;
      chk("tbl_sel", 64'({sel_a, sel_b, op, wr_acc, wr_ram,
                          rd_ram, operand}),
          64'({tbl[i].sa, tbl[i].sb, tbl[i].op, 3'b000,
               tbl_instr[10:0]}));
      step = 1'b1;
      #1;
      chk("tbl_en", 64'({wr_acc, wr_ram, rd_ram}),
          64'({tbl[i].wa, tbl[i].wr, tbl[i].rr}));
      step = 1'b0;
      @(negedge clk);
    end
    chk("tbl_pc", 64'({addr, cycles}), 64'd0);
    use_tbl = 1'b0;

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 2048; i++) begin
      logic [4:0] o;
      o = ($urandom_range(0, 9) == 0) ? 5'd0 :
          5'($urandom_range(1, 31));
      mem[i] = enc(o, 11'($urandom));
    end
    m_run = 0;
    m_halt = 0;
    m_pc = 0;
    m_cyc = 0;
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) step_mode = ~step_mode;
      step = ($urandom_range(0, 2) == 0);
      #1;
      w = mem[m_pc];
      d = ref_dec(w[15:11]);
      adv = m_run && (!step_mode || step);
      ev = 64'({11'(m_pc), w[10:0], d[6:5], d[4], d[3],
                d[2] & adv, d[1] & adv, d[0] & adv,
                m_halt, m_run, 32'(m_cyc)});
      chk("rand", dut_vec(), ev);
      if (m_run) begin
        if (adv) begin
          if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
          if (w[15:11] == 5'd0) begin
            m_run = 0;
            m_halt = 1;
          end else begin
            m_pc = (m_pc + 1) % 2048;
          end
        end
      end else if (start) begin
        m_run = 1;
        m_halt = 0;
        m_pc = 0;
        m_cyc = 0;
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
